// File: rtl/dcpu16_mram_if.sv
`default_nettype none
// dcpu16_mram_if: F-BUS and G-BUS simplified-Wishbone signals between the DCPU16 core and its memory.
interface dcpu16_mram_if;
  logic [15:0] f_adr;
  logic        f_stb;
  logic        f_wre;
  logic [15:0] f_dto;
  logic [15:0] f_dti;
  logic        f_ack;
  logic [15:0] g_adr;
  logic        g_stb;
  logic        g_wre;
  logic [15:0] g_dto;
  logic [15:0] g_dti;
  logic        g_ack;

  modport master (
    output f_adr, f_stb, f_wre, f_dto,
    input  f_dti, f_ack,
    output g_adr, g_stb, g_wre, g_dto,
    input  g_dti, g_ack
  );

  modport slave (
    input  f_adr, f_stb, f_wre, f_dto,
    output f_dti, f_ack,
    input  g_adr, g_stb, g_wre, g_dto,
    output g_dti, g_ack
  );
endinterface
`default_nettype wire

// File: rtl/dcpu16_mram.sv
`default_nettype none
// dcpu16_mram: single-ported word RAM shared by the DCPU16 F-BUS and G-BUS, with
// alternating-priority arbitration, WS wait states and a one-cycle registered ack.
module dcpu16_mram #(
  parameter int AW = 16,
  parameter int WS = 0
) (
  input  logic           clk,
  input  logic           rst,
  dcpu16_mram_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACC, ACK} state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_G = 1'b1;

  state_t          state, state_nxt;
  logic            last;
  logic            sel;
  logic [AW-1:0]   adr;
  logic            wre;
  logic [15:0]     dto;
  logic [3:0]      cnt;
  logic [15:0]     f_dti, g_dti;
  logic            f_ack, g_ack;
  logic [15:0]     mem [2**AW];

  logic            grant;
  logic            grant_sel;
  logic [AW-1:0]   grant_adr;
  logic            grant_wre;
  logic [15:0]     grant_dto;

  always_comb begin
    grant     = 1'b0;
    grant_sel = PORT_F;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.f_stb && bus.g_stb) begin
          grant     = 1'b1;
          grant_sel = ~last;
        end else if (bus.f_stb) begin
          grant     = 1'b1;
          grant_sel = PORT_F;
        end else if (bus.g_stb) begin
          grant     = 1'b1;
          grant_sel = PORT_G;
        end
      end
      WAIT: begin
        if (cnt == 4'd1) state_nxt = ACC;
      end
      ACC: state_nxt = ACK;
      ACK: begin
        // The just-acked initiator's strobe is stale here; only the other port may be granted.
        state_nxt = IDLE;
        if ((sel == PORT_F) ? bus.g_stb : bus.f_stb) begin
          grant     = 1'b1;
          grant_sel = ~sel;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant) state_nxt = (WS > 0) ? WAIT : ACC;
    grant_adr = (grant_sel == PORT_G) ? bus.g_adr[AW-1:0] : bus.f_adr[AW-1:0];
    grant_wre = (grant_sel == PORT_G) ? bus.g_wre : bus.f_wre;
    grant_dto = (grant_sel == PORT_G) ? bus.g_dto : bus.f_dto;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      last  <= PORT_G;
      sel   <= PORT_F;
      cnt   <= 4'd0;
      f_ack <= 1'b0;
      g_ack <= 1'b0;
      f_dti <= 16'h0;
      g_dti <= 16'h0;
    end else begin
      state <= state_nxt;
      f_ack <= 1'b0;
      g_ack <= 1'b0;
      if (grant) begin
        sel <= grant_sel;
        cnt <= 4'(WS);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ACC) begin
        last <= sel;
        if (sel == PORT_G) g_ack <= 1'b1;
        else               f_ack <= 1'b1;
        if (!wre) begin
          if (sel == PORT_G) g_dti <= mem[adr];
          else               f_dti <= mem[adr];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      adr <= grant_adr;
      wre <= grant_wre;
      dto <= grant_dto;
    end
    if (rst && state == ACC && wre) mem[adr] <= dto;
  end

  assign bus.f_dti = f_dti;
  assign bus.f_ack = f_ack;
  assign bus.g_dti = g_dti;
  assign bus.g_ack = g_ack;

endmodule
`default_nettype wire

// File: tb/tb_dcpu16_mram.sv
`default_nettype none
// tb_dcpu16_mram: directed checks of dcpu16_mram timing, arbitration, aliasing and reset.
module tb_dcpu16_mram;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dcpu16_mram_if b0 ();
  dcpu16_mram_if b3 ();
  dcpu16_mram_if ba ();
  dcpu16_mram_if b5 ();

  dcpu16_mram #(.AW(16), .WS(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  dcpu16_mram #(.AW(16), .WS(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  dcpu16_mram #(.AW(4),  .WS(0)) ua (.clk(clk), .rst(rst), .bus(ba));
  dcpu16_mram #(.AW(16), .WS(5)) u5 (.clk(clk), .rst(rst), .bus(b5));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    {b0.f_adr, b0.f_stb, b0.f_wre, b0.f_dto, b0.g_adr, b0.g_stb, b0.g_wre, b0.g_dto} = '0;
    {b3.f_adr, b3.f_stb, b3.f_wre, b3.f_dto, b3.g_adr, b3.g_stb, b3.g_wre, b3.g_dto} = '0;
    {ba.f_adr, ba.f_stb, ba.f_wre, ba.f_dto, ba.g_adr, ba.g_stb, ba.g_wre, ba.g_dto} = '0;
    {b5.f_adr, b5.f_stb, b5.f_wre, b5.f_dto, b5.g_adr, b5.g_stb, b5.g_wre, b5.g_dto} = '0;

    // Reset state
    rst = 1'b0;
    tick; tick;
    check1("rst_f_ack", b0.f_ack, 1'b0);
    check1("rst_g_ack", b0.g_ack, 1'b0);
    check16("rst_f_dti", b0.f_dti, 16'h0000);
    check16("rst_g_dti", b0.g_dti, 16'h0000);
    rst = 1'b1;
    tick;

    // F write 0x1234 -> 0x0010, WS=0
    b0.f_adr = 16'h0010; b0.f_wre = 1'b1; b0.f_dto = 16'h1234; b0.f_stb = 1'b1;
    tick;
    check1("wr_ack_t1", b0.f_ack, 1'b0);
    tick;
    check1("wr_ack_t2", b0.f_ack, 1'b1);
    check16("wr_f_dti_unchanged", b0.f_dti, 16'h0000);
    b0.f_stb = 1'b0; b0.f_wre = 1'b0;
    tick;
    check1("wr_ack_clear", b0.f_ack, 1'b0);

    // G read 0x0010
    b0.g_adr = 16'h0010; b0.g_stb = 1'b1;
    tick;
    check1("g_rd_ack_t1", b0.g_ack, 1'b0);
    tick;
    check1("g_rd_ack_t2", b0.g_ack, 1'b1);
    check16("g_rd_data", b0.g_dti, 16'h1234);
    b0.g_stb = 1'b0;
    tick;

    // G write 0x5678 -> 0x0020
    b0.g_adr = 16'h0020; b0.g_wre = 1'b1; b0.g_dto = 16'h5678; b0.g_stb = 1'b1;
    tick; tick;
    check1("g_wr_ack", b0.g_ack, 1'b1);
    b0.g_stb = 1'b0; b0.g_wre = 1'b0;
    tick;

    // Tie arbitration from reset: F, G, F, G with ACK-cycle hand-over
    rst = 1'b0;
    tick;
    rst = 1'b1;
    b0.f_adr = 16'h0010; b0.f_stb = 1'b1;
    b0.g_adr = 16'h0020; b0.g_stb = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      check1($sformatf("tie_f_ack_%0d", i), b0.f_ack, (i == 2 || i == 6));
      check1($sformatf("tie_g_ack_%0d", i), b0.g_ack, (i == 4 || i == 8));
      if (i == 2) begin
        check16("tie_f_dti_1", b0.f_dti, 16'h1234);
        b0.f_adr = 16'h0020;
      end
      if (i == 4) begin
        check16("tie_g_dti_1", b0.g_dti, 16'h5678);
        b0.g_adr = 16'h0010;
      end
      if (i == 6) begin
        check16("tie_f_dti_2", b0.f_dti, 16'h5678);
        b0.f_stb = 1'b0;
      end
      if (i == 8) begin
        check16("tie_g_dti_2", b0.g_dti, 16'h1234);
        b0.g_stb = 1'b0;
      end
    end
    tick;

    // Wait states, WS=3: write then read 0x0000
    b3.f_adr = 16'h0000; b3.f_wre = 1'b1; b3.f_dto = 16'hC0DE; b3.f_stb = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick;
      check1($sformatf("ws3_wr_ack_%0d", i), b3.f_ack, (i == 5));
    end
    b3.f_stb = 1'b0; b3.f_wre = 1'b0;
    tick;
    b3.f_stb = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick;
      check1($sformatf("ws3_rd_ack_%0d", i), b3.f_ack, (i == 5));
      if (i == 5) begin
        check16("ws3_rd_data", b3.f_dti, 16'hC0DE);
        b3.f_stb = 1'b0;
      end
    end

    // Aliasing, AW=4
    ba.f_adr = 16'h0013; ba.f_wre = 1'b1; ba.f_dto = 16'hBEEF; ba.f_stb = 1'b1;
    tick; tick;
    check1("alias_wr_ack", ba.f_ack, 1'b1);
    ba.f_stb = 1'b0; ba.f_wre = 1'b0;
    tick;
    ba.f_adr = 16'h0003; ba.f_stb = 1'b1;
    tick; tick;
    check1("alias_rd_ack", ba.f_ack, 1'b1);
    check16("alias_rd_data", ba.f_dti, 16'hBEEF);
    ba.f_stb = 1'b0;
    tick;

    // Reset mid-operation, WS=5
    b5.f_adr = 16'h0020; b5.f_wre = 1'b1; b5.f_dto = 16'h5555; b5.f_stb = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick;
      check1($sformatf("ws5_wr_ack_%0d", i), b5.f_ack, (i == 7));
    end
    b5.f_stb = 1'b0; b5.f_wre = 1'b0;
    tick;
    b5.f_wre = 1'b1; b5.f_dto = 16'hAAAA; b5.f_stb = 1'b1;
    tick; tick;
    rst = 1'b0; b5.f_stb = 1'b0; b5.f_wre = 1'b0;
    tick;
    check1("midrst_ack", b5.f_ack, 1'b0);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick;
      check1($sformatf("midrst_no_ack_%0d", i), b5.f_ack, 1'b0);
    end
    b5.f_stb = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick;
      check1($sformatf("midrst_rd_ack_%0d", i), b5.f_ack, (i == 7));
    end
    check16("midrst_rd_data", b5.f_dti, 16'h5555);
    b5.f_stb = 1'b0;
    tick;

    // Stale-strobe guard: preload 0x1..0x3 then stream reads with stb held
    for (int k = 1; k <= 3; k++) begin
      b0.f_adr = 16'(k); b0.f_wre = 1'b1; b0.f_dto = 16'hA000 + 16'(k); b0.f_stb = 1'b1;
      tick; tick;
      check1($sformatf("pre_wr_ack_%0d", k), b0.f_ack, 1'b1);
      b0.f_stb = 1'b0; b0.f_wre = 1'b0;
      tick;
    end
    b0.f_adr = 16'h0001; b0.f_stb = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick;
      check1($sformatf("stale_ack_%0d", i), b0.f_ack, (i == 2 || i == 5 || i == 8));
      if (i == 2 || i == 5 || i == 8) begin
        check16($sformatf("stale_data_%0d", i), b0.f_dti, 16'hA000 + b0.f_adr);
        b0.f_adr = b0.f_adr + 16'h1;
        if (i == 8) b0.f_stb = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
